// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing shared by the sync generator
// and the colour stages downstream of it.
package vga_timing_pkg;

    localparam int VGA_CNT_W = 10;

    localparam int VGA_H_VIS  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;

    localparam int VGA_V_VIS  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;

    localparam int VGA_H_TOTAL =
        VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL =
        VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int VGA_HS_START = VGA_H_VIS + VGA_H_FP;
    localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;
    localparam int VGA_VS_START = VGA_V_VIS + VGA_V_FP;
    localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

    typedef logic [VGA_CNT_W-1:0] vga_cnt_t;

    function automatic int vga_total(
        input int vis,
        input int fp,
        input int sync,
        input int bp
    );
        return vis + fp + sync + bp;
    endfunction

    function automatic logic vga_in_win(
        input vga_cnt_t c,
        input int       lo,
        input int       hi
    );
        return (int'(c) >= lo) && (int'(c) <= hi);
    endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel-rate divider: one-clk tick every CLK_DIV system clocks.
// With CLK_DIV=1 the tick is permanently high.
module vga_pixel_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] r_div;

    assign tick = (r_div == DIV_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
        end else if (tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster counters and registered sync/pixel outputs. Outputs load from
// the next counter values on each tick so they all move on one edge.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV         = 2,
    parameter int H_VIS           = VGA_H_VIS,
    parameter int H_FP            = VGA_H_FP,
    parameter int H_SYNC          = VGA_H_SYNC,
    parameter int H_BP            = VGA_H_BP,
    parameter int V_VIS           = VGA_V_VIS,
    parameter int V_FP            = VGA_V_FP,
    parameter int V_SYNC          = VGA_V_SYNC,
    parameter int V_BP            = VGA_V_BP,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 pixel_on,
    output logic [VGA_CNT_W-1:0] x,
    output logic [VGA_CNT_W-1:0] y,
    output logic                 pixel_tick,
    output logic                 frame_start
);

    localparam int H_TOTAL = vga_total(H_VIS, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_total(V_VIS, V_FP, V_SYNC, V_BP);
    localparam int HS_LO   = H_VIS + H_FP;
    localparam int HS_HI   = HS_LO + H_SYNC - 1;
    localparam int VS_LO   = V_VIS + V_FP;
    localparam int VS_HI   = VS_LO + V_SYNC - 1;

    localparam vga_cnt_t H_LAST = vga_cnt_t'(H_TOTAL - 1);
    localparam vga_cnt_t V_LAST = vga_cnt_t'(V_TOTAL - 1);
    localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

    logic     w_tick;
    logic     w_h_wrap;
    logic     w_pix_on;
    logic     w_hs_act;
    logic     w_vs_act;
    logic     w_first;
    vga_cnt_t w_h_nxt;
    vga_cnt_t w_v_nxt;
    vga_cnt_t r_h;
    vga_cnt_t r_v;

    vga_pixel_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_pixel_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (w_tick)
    );

    always_comb begin
        w_h_wrap = (r_h == H_LAST);
        w_h_nxt  = w_h_wrap ? '0 : r_h + vga_cnt_t'(1);
        w_v_nxt  = r_v;
        if (w_h_wrap) begin
            w_v_nxt = (r_v == V_LAST) ? '0 : r_v + vga_cnt_t'(1);
        end
        w_pix_on = (int'(w_h_nxt) < H_VIS) && (int'(w_v_nxt) < V_VIS);
        w_hs_act = vga_in_win(w_h_nxt, HS_LO, HS_HI);
        w_vs_act = vga_in_win(w_v_nxt, VS_LO, VS_HI);
        w_first  = (w_h_nxt == '0) && (w_v_nxt == '0);
    end

    // Counters park on the last position so the first tick enters (0,0).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_h         <= H_LAST;
            r_v         <= V_LAST;
            x           <= '0;
            y           <= '0;
            pixel_on    <= 1'b0;
            hsync       <= SYNC_IDLE;
            vsync       <= SYNC_IDLE;
            pixel_tick  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pixel_tick  <= w_tick;
            frame_start <= w_tick && w_first;
            if (w_tick) begin
                r_h      <= w_h_nxt;
                r_v      <= w_v_nxt;
                x        <= w_h_nxt;
                y        <= w_v_nxt;
                pixel_on <= w_pix_on;
                hsync    <= SYNC_IDLE ^ w_hs_act;
                vsync    <= SYNC_IDLE ^ w_vs_act;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full-size timing at CLK_DIV=2, plus two shrunken
// rasters (15x8) for whole-frame, CLK_DIV=1 and active-high sync cases.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic       hs0, vs0, on0, pt0, fs0;
    logic [9:0] x0, y0;
    logic       hs1, vs1, on1, pt1, fs1;
    logic [9:0] x1, y1;
    logic       hs2, vs2, on2, pt2, fs2;
    logic [9:0] x2, y2;

    wire [24:0] o0 = {x0, y0, on0, hs0, vs0, pt0, fs0};
    wire [24:0] o1 = {x1, y1, on1, hs1, vs1, pt1, fs1};
    wire [24:0] o2 = {x2, y2, on2, hs2, vs2, pt2, fs2};

    int errors = 0;
    int checks = 0;
    int edges  = 0;

    vga_sync_gen u_dut0 (
        .clk        (clk),
        .reset_n    (rst_n),
        .hsync      (hs0),
        .vsync      (vs0),
        .pixel_on   (on0),
        .x          (x0),
        .y          (y0),
        .pixel_tick (pt0),
        .frame_start(fs0)
    );

    vga_sync_gen #(
        .CLK_DIV(1),
        .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_ACTIVE_LOW(1)
    ) u_dut1 (
        .clk        (clk),
        .reset_n    (rst_n),
        .hsync      (hs1),
        .vsync      (vs1),
        .pixel_on   (on1),
        .x          (x1),
        .y          (y1),
        .pixel_tick (pt1),
        .frame_start(fs1)
    );

    vga_sync_gen #(
        .CLK_DIV(3),
        .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_ACTIVE_LOW(0)
    ) u_dut2 (
        .clk        (clk),
        .reset_n    (rst_n),
        .hsync      (hs2),
        .vsync      (vs2),
        .pixel_on   (on2),
        .x          (x2),
        .y          (y2),
        .pixel_tick (pt2),
        .frame_start(fs2)
    );

    function automatic logic [24:0] mk(
        input int x, input int y,
        input logic on, input logic hs, input logic vs,
        input logic pt, input logic fs
    );
        return {10'(x), 10'(y), on, hs, vs, pt, fs};
    endfunction

    function automatic string fmt(input logic [24:0] v);
        return $sformatf("x=%0d y=%0d on=%b hs=%b vs=%b pt=%b fs=%b",
            v[24:15], v[14:5], v[4], v[3], v[2], v[1], v[0]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic step_to(input int n);
        while (edges < n) step();
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        edges = 0;
    endtask

    task automatic test_reset();
        logic [24:0] e;
        hold_reset();
        e = mk(0, 0, 0, 1, 1, 0, 0);
        checks++;
        if (o0 !== e) begin
            errors++;
            $display("FAIL reset_d0: got %s want %s", fmt(o0), fmt(e));
        end
        e = mk(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (o2 !== e) begin
            errors++;
            $display("FAIL reset_d2: got %s want %s", fmt(o2), fmt(e));
        end
        step();
        e = mk(0, 0, 0, 1, 1, 0, 0);
        checks++;
        if (o0 !== e) begin
            errors++;
            $display("FAIL edge1_d0: got %s want %s", fmt(o0), fmt(e));
        end
        e = mk(0, 0, 1, 1, 1, 1, 1);
        checks++;
        if (o1 !== e) begin
            errors++;
            $display("FAIL edge1_d1: got %s want %s", fmt(o1), fmt(e));
        end
        step();
        e = mk(0, 0, 1, 1, 1, 1, 1);
        checks++;
        if (o0 !== e) begin
            errors++;
            $display("FAIL edge2_d0: got %s want %s", fmt(o0), fmt(e));
        end
        step();
        e = mk(0, 0, 1, 1, 1, 0, 0);
        checks++;
        if (o0 !== e) begin
            errors++;
            $display("FAIL edge3_d0: got %s want %s", fmt(o0), fmt(e));
        end
        e = mk(0, 0, 1, 0, 0, 1, 1);
        checks++;
        if (o2 !== e) begin
            errors++;
            $display("FAIL edge3_d2: got %s want %s", fmt(o2), fmt(e));
        end
        step();
        e = mk(1, 0, 1, 1, 1, 1, 0);
        checks++;
        if (o0 !== e) begin
            errors++;
            $display("FAIL edge4_d0: got %s want %s", fmt(o0), fmt(e));
        end
    endtask

    task automatic test_line();
        logic [24:0] e;
        int lo;
        step_to(1280);
        e = mk(639, 0, 1, 1, 1, 1, 0);
        checks++;
        if (o0 !== e) begin
            errors++;
            $display("FAIL x639: got %s want %s", fmt(o0), fmt(e));
        end
        step_to(1282);
        e = mk(640, 0, 0, 1, 1, 1, 0);
        checks++;
        if (o0 !== e) begin
            errors++;
            $display("FAIL x640: got %s want %s", fmt(o0), fmt(e));
        end
        lo = 0;
        while (edges < 1520) begin
            step();
            if (!hs0) lo++;
            if (edges == 1314) begin
                e = mk(656, 0, 0, 0, 1, 1, 0);
                checks++;
                if (o0 !== e) begin
                    errors++;
                    $display("FAIL hs_fall: got %s want %s",
                        fmt(o0), fmt(e));
                end
            end
            if (edges == 1506) begin
                e = mk(752, 0, 0, 1, 1, 1, 0);
                checks++;
                if (o0 !== e) begin
                    errors++;
                    $display("FAIL hs_rise: got %s want %s",
                        fmt(o0), fmt(e));
                end
            end
        end
        checks++;
        if (lo !== 192) begin
            errors++;
            $display("FAIL hs_width: got %0d clks want 192", lo);
        end
        step_to(1600);
        e = mk(799, 0, 0, 1, 1, 1, 0);
        checks++;
        if (o0 !== e) begin
            errors++;
            $display("FAIL x799: got %s want %s", fmt(o0), fmt(e));
        end
        step_to(1602);
        e = mk(0, 1, 1, 1, 1, 1, 0);
        checks++;
        if (o0 !== e) begin
            errors++;
            $display("FAIL line2: got %s want %s", fmt(o0), fmt(e));
        end
    endtask

    task automatic test_midline_reset();
        logic [24:0] e;
        step_to(2202);
        e = mk(300, 1, 1, 1, 1, 1, 0);
        checks++;
        if (o0 !== e) begin
            errors++;
            $display("FAIL x300: got %s want %s", fmt(o0), fmt(e));
        end
        #2;
        rst_n = 1'b0;
        #1;
        e = mk(0, 0, 0, 1, 1, 0, 0);
        checks++;
        if (o0 !== e) begin
            errors++;
            $display("FAIL async_rst: got %s want %s", fmt(o0), fmt(e));
        end
        step();
        rst_n = 1'b1;
        edges = 0;
        step();
        checks++;
        if (o0 !== e) begin
            errors++;
            $display("FAIL rel_edge1: got %s want %s", fmt(o0), fmt(e));
        end
        step();
        e = mk(0, 0, 1, 1, 1, 1, 1);
        checks++;
        if (o0 !== e) begin
            errors++;
            $display("FAIL rel_edge2: got %s want %s", fmt(o0), fmt(e));
        end
    endtask

    task automatic test_frame_div1();
        logic [24:0] e;
        int nfs, fsa, fsb, ptz, vlo, hlo, non;
        nfs = 0; fsa = -1; fsb = -1;
        ptz = 0; vlo = 0; hlo = 0; non = 0;
        hold_reset();
        while (edges < 240) begin
            step();
            if (fs1) begin
                nfs++;
                if (fsa < 0) fsa = edges;
                else if (fsb < 0) fsb = edges;
            end
            if (!pt1) ptz++;
            if (!vs1) vlo++;
            if (!hs1) hlo++;
            if (on1) non++;
            if (edges == 75) begin
                e = mk(14, 4, 0, 1, 1, 1, 0);
                checks++;
                if (o1 !== e) begin
                    errors++;
                    $display("FAIL d1_pre_vs: got %s want %s",
                        fmt(o1), fmt(e));
                end
            end
            if (edges == 76) begin
                e = mk(0, 5, 0, 1, 0, 1, 0);
                checks++;
                if (o1 !== e) begin
                    errors++;
                    $display("FAIL d1_vs_fall: got %s want %s",
                        fmt(o1), fmt(e));
                end
            end
            if (edges == 120) begin
                e = mk(14, 7, 0, 1, 1, 1, 0);
                checks++;
                if (o1 !== e) begin
                    errors++;
                    $display("FAIL d1_last: got %s want %s",
                        fmt(o1), fmt(e));
                end
            end
            if (edges == 121) begin
                e = mk(0, 0, 1, 1, 1, 1, 1);
                checks++;
                if (o1 !== e) begin
                    errors++;
                    $display("FAIL d1_wrap: got %s want %s",
                        fmt(o1), fmt(e));
                end
            end
        end
        checks++;
        if (nfs !== 2 || fsa !== 1 || fsb !== 121) begin
            errors++;
            $display("FAIL d1_fs: got n=%0d at %0d,%0d want 2 at 1,121",
                nfs, fsa, fsb);
        end
        checks++;
        if (ptz !== 0) begin
            errors++;
            $display("FAIL d1_pt_const: got %0d low clks want 0", ptz);
        end
        checks++;
        if (vlo !== 60) begin
            errors++;
            $display("FAIL d1_vs_low: got %0d want 60", vlo);
        end
        checks++;
        if (hlo !== 48) begin
            errors++;
            $display("FAIL d1_hs_low: got %0d want 48", hlo);
        end
        checks++;
        if (non !== 64) begin
            errors++;
            $display("FAIL d1_pix_on: got %0d want 64", non);
        end
    endtask

    task automatic test_polarity_div3();
        logic [24:0] e;
        int nfs, fsa, fsb, npt, vhi, hhi;
        nfs = 0; fsa = -1; fsb = -1;
        npt = 0; vhi = 0; hhi = 0;
        hold_reset();
        while (edges < 363) begin
            step();
            if (fs2) begin
                nfs++;
                if (fsa < 0) fsa = edges;
                else if (fsb < 0) fsb = edges;
            end
            if (pt2) npt++;
            if (vs2) vhi++;
            if (hs2) hhi++;
            if (edges == 2) begin
                e = mk(0, 0, 0, 0, 0, 0, 0);
                checks++;
                if (o2 !== e) begin
                    errors++;
                    $display("FAIL d2_edge2: got %s want %s",
                        fmt(o2), fmt(e));
                end
            end
            if (edges == 228) begin
                e = mk(0, 5, 0, 0, 1, 1, 0);
                checks++;
                if (o2 !== e) begin
                    errors++;
                    $display("FAIL d2_vs_rise: got %s want %s",
                        fmt(o2), fmt(e));
                end
            end
        end
        checks++;
        if (nfs !== 2 || fsa !== 3 || fsb !== 363) begin
            errors++;
            $display("FAIL d2_fs: got n=%0d at %0d,%0d want 2 at 3,363",
                nfs, fsa, fsb);
        end
        checks++;
        if (npt !== 121) begin
            errors++;
            $display("FAIL d2_ticks: got %0d want 121", npt);
        end
        checks++;
        if (vhi !== 90) begin
            errors++;
            $display("FAIL d2_vs_high: got %0d want 90", vhi);
        end
        checks++;
        if (hhi !== 72) begin
            errors++;
            $display("FAIL d2_hs_high: got %0d want 72", hhi);
        end
    endtask

    initial begin
        #3;
        test_reset();
        test_line();
        test_midline_reset();
        test_frame_div1();
        test_polarity_div3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator for the VGA system. Divides the system clock into a pixel rate, runs horizontal and vertical counters over a full 640x480@60 Hz frame, and drives registered hsync/vsync to the connector. It also feeds pixel_on, x and y to the colour stages directly downstream (the band colouriser and its siblings), which consume them combinationally.

## Interface
- CLK_DIV, 2, system clocks per pixel (50 MHz -> 25 MHz); legal 1..16
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- SYNC_ACTIVE_LOW, 1, 1 = sync pulses low

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- hsync  output  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
- vsync  output  1  vertical sync, polarity per SYNC_ACTIVE_LOW
- pixel_on  output  1  high while (x,y) is inside the visible area
- x  output  10  current column, 0..H_TOTAL-1
- y  output  10  current line, 0..V_TOTAL-1
- pixel_tick  output  1  one-clk strobe; high in the clk cycle in which outputs have just advanced
- frame_start  output  1  one-clk strobe; high in the cycle in which outputs show (0,0)

## Operation
- H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (525). Both must fit in 10 bits.
- Divider div_cnt counts 0..CLK_DIV-1. The internal tick fires when div_cnt == CLK_DIV-1, then div_cnt wraps to 0. With CLK_DIV=1, the tick fires every clk.
- On a tick, h_cnt increments. At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments. At v_cnt = V_TOTAL-1 with h_cnt wrapping, v_cnt wraps to 0. There is no other wrap path.
- Internal counters reset to (H_TOTAL-1, V_TOTAL-1), so the first tick after reset enters (0,0).
- All outputs are registered. They are computed from the next counter values and loaded on the tick edge, so x, y, pixel_on, hsync and vsync change on the same edge with zero skew.
- pixel_on = (h < H_VIS) && (v < V_VIS).
- hsync is active for h in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] (656..751).
- vsync is active for v in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1] (490..491), across whole lines.
- "Active" means 0 when SYNC_ACTIVE_LOW=1, else 1.
- frame_start is registered and high for exactly one clk when the outputs load (0,0).
- Reset values, held until the first tick:
  - x=0, y=0, pixel_on=0
  - hsync and vsync inactive (1 for active-low)
  - pixel_tick=0, frame_start=0, div_cnt=0
- Reset asserted mid-frame: all state returns to reset values immediately and asynchronously. No partial line is completed.

## Timing
- After reset_n deasserts, the first output update occurs on the CLK_DIV-th rising clk edge. At that edge: x=0, y=0, pixel_on=1, pixel_tick=1, frame_start=1.
- Between ticks, outputs are stable for exactly CLK_DIV clks.
- Line period: H_TOTAL*CLK_DIV clks (1600). Frame period: H_TOTAL*V_TOTAL*CLK_DIV clks (840000).
- End-of-frame wrap: (799,524) -> (0,0) on one tick. frame_start pulses on that edge and on no other.
- hsync edges land on the x=656 and x=752 update edges. vsync edges land on the (0,490) and (0,492) update edges.

## Structure
- Shared package vga_timing_pkg holds the default timing constants, the derived H_TOTAL/V_TOTAL, and the sync window bounds. Colour stages use the same package for H_VIS/V_VIS.
- Sub-module vga_pixel_tick holds the div_cnt divider. Parameter CLK_DIV. Ports: clk, reset_n, tick.
- Counters, decode and output registers stay in vga_sync_gen.

## Test plan
- Reset release, CLK_DIV=2 -> first update on the 2nd edge. (x,y)=(0,0), pixel_on=1, frame_start=1 for one clk. Before that edge: x=y=0, pixel_on=0, hsync=vsync=1.
- Run one line -> pixel_on falls at the x=640 update. hsync is low from x=656 through x=751 (96 ticks = 192 clks). The next line starts after 1600 clks, with y=1.
- Run one full frame -> vsync is low for exactly 2 lines (3200 clks) starting at y=490. frame_start pulses exactly twice, 840000 clks apart. There are 800*525 tick strobes.
- Assert reset_n at (x=300, y=200) mid-line -> outputs return to reset values with no clock edge. After release, the sequence restarts per scenario 1.
- CLK_DIV=1 -> pixel_tick is constant 1 after the first edge. Line period is 800 clks. The (799,524)->(0,0) wrap happens in one clk.
- SYNC_ACTIVE_LOW=0 -> hsync and vsync are inverted relative to scenarios 2–3, and reset to 0.
